// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: wraps a raw 32-bit sample stream into framer words
// (header, timestamp MSB/LSB, NB_SAMPLES payload words, FCS). A small sample
// buffer absorbs the four overhead words of each frame.
module rx_frame_sequencer #(
    parameter int unsigned NB_SAMPLES = 256,
    parameter int unsigned BUF_AW     = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_sample_valid,
    input  logic [31:0] i_sample,
    input  logic        i_fifo_full,
    output logic [3:0]  o_data_tag,
    output logic [31:0] o_data,
    output logic        o_frame_active,
    output logic [15:0] o_overflow_cnt,
    output logic [15:0] o_frames_sent
);

    localparam int unsigned DEPTH = 1 << BUF_AW;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned LVL_W = BUF_AW + 1;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NB_SAMPLES - 1);

    localparam logic [3:0] TAG_NONE = 4'd0;
    localparam logic [3:0] TAG_HDR  = 4'd2;
    localparam logic [3:0] TAG_TSM  = 4'd4;
    localparam logic [3:0] TAG_TSL  = 4'd6;
    localparam logic [3:0] TAG_FCS  = 4'd8;
    localparam logic [3:0] TAG_PAY  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_TSM,
        ST_TSL,
        ST_PAY,
        ST_FCS
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BUF_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [BUF_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [15:0]         ovf_q, ovf_d;
    logic [15:0]         frames_q, frames_d;
    logic [31:0]         buf_mem [DEPTH];

    logic       buf_empty;
    logic       buf_full;
    logic [3:0] tag_c;
    logic       consume;
    logic       pop;
    logic       push_req;
    logic       push;
    logic       drop;

    // Tag/data decode from registered state and buffer head only
    always_comb begin
        buf_empty = (level_q == '0);
        buf_full  = (level_q == FULL_LVL);
        tag_c     = TAG_NONE;
        unique case (state_q)
            ST_HDR:  tag_c = TAG_HDR;
            ST_TSM:  tag_c = TAG_TSM;
            ST_TSL:  tag_c = TAG_TSL;
            ST_PAY:  tag_c = buf_empty ? TAG_NONE : TAG_PAY;
            ST_FCS:  tag_c = TAG_FCS;
            default: tag_c = TAG_NONE;
        endcase
    end

    // Handshake: consume, buffer pop/push and overflow drop
    always_comb begin
        consume  = (tag_c != TAG_NONE) && !i_fifo_full;
        pop      = consume && (state_q == ST_PAY);
        push_req = i_sample_valid && i_enable;
        push     = push_req && (!buf_full || pop);
        drop     = push_req && !push;
    end

    // Frame sequencing FSM next state and payload counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frames_d = frames_q;
        unique case (state_q)
            ST_IDLE: if (i_enable) state_d = ST_HDR;
            ST_HDR:  if (consume) state_d = ST_TSM;
            ST_TSM:  if (consume) state_d = ST_TSL;
            ST_TSL: begin
                if (consume) begin
                    state_d = ST_PAY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_PAY: begin
                if (consume) begin
                    if (cnt_q == '0) state_d = ST_FCS;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_FCS: begin
                if (consume) begin
                    frames_d = frames_q + 16'd1;
                    state_d  = i_enable ? ST_HDR : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Buffer pointers, occupancy and saturating overflow counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + BUF_AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + BUF_AW'(1);
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);
        if (drop && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
    end

    // Control state registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            frames_q <= frames_d;
        end
    end

    // Sample storage; contents are don't-care until the pointers mark them valid
    always_ff @(posedge i_clk) begin
        if (push) buf_mem[wr_ptr_q] <= i_sample;
    end

    assign o_data_tag     = tag_c;
    assign o_data         = (tag_c == TAG_PAY) ? buf_mem[rd_ptr_q] : 32'd0;
    assign o_frame_active = (state_q != ST_IDLE);
    assign o_overflow_cnt = ovf_q;
    assign o_frames_sent  = frames_q;

endmodule
